// File: rtl/mini_alu_gen2_if.sv
// Instruction-ROM and status bus of the mini ALU core.
// The core (slave) presents its instruction pointer and status; the ROM/host
// side (master) returns the instruction word addressed by oIP combinationally.
interface mini_alu_gen2_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LED_WIDTH  = 8
);
  localparam int INSTR_WIDTH = 4 + 3 * ADDR_WIDTH;

  logic [INSTR_WIDTH-1:0] iInstruction;
  logic [ADDR_WIDTH-1:0]  oIP;
  logic [LED_WIDTH-1:0]   oLed;
  logic                   oBusy;
  logic                   oHalted;

  modport master (
    output iInstruction,
    input  oIP,
    input  oLed,
    input  oBusy,
    input  oHalted
  );

  modport slave (
    input  iInstruction,
    output oIP,
    output oLed,
    output oBusy,
    output oHalted
  );
endinterface

// File: rtl/mini_alu_gen2.sv
// Two-stage fetch/execute mini ALU with a 2^ADDR_WIDTH-word register file,
// an iterative shift-add multiplier, branches with a one-cycle penalty and HALT.
module mini_alu_gen2 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LED_WIDTH  = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  mini_alu_gen2_if.slave bus
);

  localparam int INSTR_WIDTH = 4 + 3 * ADDR_WIDTH;
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);
  localparam int CNT_WIDTH   = $clog2(DATA_WIDTH);
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LED   = 4'h1,
    OP_STO   = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_MUL   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_BLE   = 4'h8,
    OP_BEQ   = 4'h9,
    OP_JMP   = 4'hA,
    OP_RSV_B = 4'hB,
    OP_RSV_C = 4'hC,
    OP_RSV_D = 4'hD,
    OP_RSV_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  // Architectural state
  logic [DATA_WIDTH-1:0]  rf [2**ADDR_WIDTH];
  logic [INSTR_WIDTH-1:0] exec_instr;
  logic [ADDR_WIDTH-1:0]  ip;
  logic [LED_WIDTH-1:0]   led;
  logic                   halted;

  // Multiplier state: iteration counter plus running sum and shifted operands
  logic [CNT_WIDTH-1:0]  mul_cnt;
  logic [DATA_WIDTH-1:0] mul_acc;
  logic [DATA_WIDTH-1:0] mul_mcand;
  logic [DATA_WIDTH-1:0] mul_mplier;

  // Instruction decode
  opcode_e               opcode;
  logic [ADDR_WIDTH-1:0] dest;
  logic [ADDR_WIDTH-1:0] src1;
  logic [ADDR_WIDTH-1:0] src0;
  logic [DATA_WIDTH-1:0] d0;
  logic [DATA_WIDTH-1:0] d1;
  logic [DATA_WIDTH-1:0] imm;

  assign opcode = opcode_e'(exec_instr[INSTR_WIDTH-1 -: 4]);
  assign dest   = exec_instr[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign src1   = exec_instr[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign src0   = exec_instr[ADDR_WIDTH-1:0];
  assign d0     = rf[src0];
  assign d1     = rf[src1];
  assign imm    = DATA_WIDTH'({src1, src0});

  // Multiply step: the first cycle works straight from the register file,
  // later cycles from the latched copies, so dest may alias a source.
  logic                  is_mul;
  logic                  mul_first;
  logic                  mul_last;
  logic [DATA_WIDTH-1:0] cur_acc;
  logic [DATA_WIDTH-1:0] cur_mcand;
  logic [DATA_WIDTH-1:0] cur_mplier;
  logic [DATA_WIDTH-1:0] next_acc;

  assign is_mul     = (opcode == OP_MUL);
  assign mul_first  = (mul_cnt == '0);
  assign mul_last   = (mul_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign cur_acc    = mul_first ? '0 : mul_acc;
  assign cur_mcand  = mul_first ? d1 : mul_mcand;
  assign cur_mplier = mul_first ? d0 : mul_mplier;
  assign next_acc   = cur_acc + (cur_mplier[0] ? cur_mcand : '0);

  // Execute-stage control decoded from the instruction in the execute register
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  led_we;
  logic                  branch_taken;
  logic                  mul_hold;
  logic                  halt_now;

  // Decode the executing opcode into write, branch, stall and halt controls
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rf_we        = 1'b0;
    rf_wdata     = '0;
    led_we       = 1'b0;
    branch_taken = 1'b0;
    mul_hold     = 1'b0;
    halt_now     = 1'b0;
    case (opcode)
      OP_LED:  led_we = 1'b1;
      OP_STO:  begin rf_we = 1'b1; rf_wdata = imm;                    end
      OP_ADD:  begin rf_we = 1'b1; rf_wdata = d1 + d0;                end
      OP_SUB:  begin rf_we = 1'b1; rf_wdata = d1 - d0;                end
      OP_SHL:  begin rf_we = 1'b1; rf_wdata = d1 << d0[SHIFT_WIDTH-1:0]; end
      OP_SHR:  begin rf_we = 1'b1; rf_wdata = d1 >> d0[SHIFT_WIDTH-1:0]; end
      OP_MUL:  begin
        mul_hold = !mul_last;
        rf_we    = mul_last;
        rf_wdata = next_acc;
      end
      OP_BLE:  branch_taken = (d1 <= d0);
      OP_BEQ:  branch_taken = (d1 == d0);
      OP_JMP:  branch_taken = 1'b1;
      OP_HALT: halt_now = 1'b1;
      default: ;
    endcase
  end

  // Register-file write port; a reset in the same cycle suppresses the write
  always_ff @(posedge Clock) begin
    // NOTE: the register file is deliberately not reset; software writes before it reads.
    if (rf_we && !Reset) begin
      rf[dest] <= rf_wdata;
    end
  end

  // Multiplier datapath; only consumed after its first cycle has loaded it
  always_ff @(posedge Clock) begin
    if (is_mul) begin
      mul_acc    <= next_acc;
      mul_mcand  <= cur_mcand << 1;
      mul_mplier <= cur_mplier >> 1;
    end
  end

  // Fetch, instruction pointer, LED, multiply counter and halt control
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (Reset) begin
      ip         <= '0;
      exec_instr <= NOP_INSTR;
      led        <= '0;
      halted     <= 1'b0;
      mul_cnt    <= '0;
    end else begin
      if (led_we) begin
        led <= d1[LED_WIDTH-1:0];
      end
      if (is_mul) begin
        mul_cnt <= mul_last ? '0 : mul_cnt + CNT_WIDTH'(1);
      end
      if (halt_now) begin
        halted     <= 1'b1;
        exec_instr <= NOP_INSTR;
      end else if (!halted && !mul_hold) begin
        if (branch_taken) begin
          ip         <= dest;
          exec_instr <= NOP_INSTR;
        end else begin
          exec_instr <= bus.iInstruction;
          ip         <= ip + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign bus.oIP     = ip;
  assign bus.oLed    = led;
  assign bus.oBusy   = is_mul;
  assign bus.oHalted = halted;

endmodule

// File: tb/tb_mini_alu_gen2.sv
// Directed bench for mini_alu_gen2: small programs are loaded into a ROM model,
// expected LED values go into a scoreboard queue, and a monitor compares every
// LED update; timing properties are checked directly against hand-derived values.
module tb_mini_alu_gen2;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LED  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_BLE  = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct {
    string      name;
    logic [7:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;
  logic [27:0] rom [256];
  logic [7:0] last_led = 8'h00;
  exp_t exp_q [$];
  int pass_count = 0;
  int total_count = 0;

  mini_alu_gen2_if #(.ADDR_WIDTH(AW), .LED_WIDTH(LW)) bus ();

  mini_alu_gen2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LED_WIDTH(LW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.iInstruction = rom[bus.oIP];

  function automatic logic [27:0] ins(logic [3:0] op, logic [7:0] d, logic [7:0] s1, logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(logic [7:0] d, logic [15:0] value);
    return {4'h2, d, value};
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic expect_led(string name, logic [7:0] value);
    exp_t e;
    e.name  = name;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic fill_rom(logic [27:0] value);
    for (int i = 0; i < 256; i++) rom[i] = value;
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Counts edges after reset release until oHalted is seen, bounded by budget
  task automatic run_to_halt(string name, int budget, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!bus.oHalted && edges < budget);
    check({name, "_halted"}, {31'd0, bus.oHalted}, 32'd1);
  endtask

  // Reset as seen by the DUT on the last edge, so reset-driven LED clears are ignored
  always @(posedge clk) rst_seen <= rst;

  // Scoreboard monitor: every LED update outside reset pops one expected value
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      last_led = bus.oLed;
    end else if (bus.oLed !== last_led) begin
      last_led = bus.oLed;
      total_count++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_led: oLed=0x%02h, expected no update", bus.oLed);
      end else begin
        e = exp_q.pop_front();
        if (bus.oLed === e.value) pass_count++;
        else $display("FAIL %s: oLed=0x%02h, expected 0x%02h", e.name, bus.oLed, e.value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int bad;
    int busy_n;
    int first_len;
    int runs;
    logic prev_busy;

    // Reset state, IP counting and wrap-around on a NOP-filled ROM
    hold_reset();
    fill_rom({OP_NOP, 24'h0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ip",     {24'd0, bus.oIP},     32'd0);
    check("reset_led",    {24'd0, bus.oLed},    32'd0);
    check("reset_busy",   {31'd0, bus.oBusy},   32'd0);
    check("reset_halted", {31'd0, bus.oHalted}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk);
      if (k < 3 || k >= 255) check($sformatf("ip_count_%0d", k), {24'd0, bus.oIP}, k % 256);
    end

    // ADD: 5 + 3 = 8
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(1, 16'h0005);
    rom[1] = sto(2, 16'h0003);
    rom[2] = ins(OP_ADD, 3, 1, 2);
    rom[3] = ins(OP_LED, 0, 3, 0);
    expect_led("add_led", 8'h08);
    release_reset();
    run_to_halt("add", 50, edges);

    // SUB wraps: 3 - 5 = 0xFFFE
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(1, 16'h0003);
    rom[1] = sto(2, 16'h0005);
    rom[2] = ins(OP_SUB, 3, 1, 2);
    rom[3] = ins(OP_LED, 0, 3, 0);
    expect_led("sub_led", 8'hFE);
    release_reset();
    run_to_halt("sub", 50, edges);

    // Shifts use only the low 4 bits of the amount (0x14 -> 4)
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(1, 16'h00F3);
    rom[1] = sto(2, 16'h0014);
    rom[2] = ins(OP_SHR, 4, 1, 2);
    rom[3] = ins(OP_LED, 0, 4, 0);
    rom[4] = ins(OP_SHL, 5, 1, 2);
    rom[5] = ins(OP_LED, 0, 5, 0);
    expect_led("shr_led", 8'h0F);
    expect_led("shl_led", 8'h30);
    release_reset();
    run_to_halt("shift", 50, edges);

    // MUL 0x123*0x10 = 0x1230, then MUL R1=R1*R1 = 0x14AC9 -> 0x4AC9
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(1, 16'h0123);
    rom[1] = sto(2, 16'h0010);
    rom[2] = ins(OP_MUL, 3, 1, 2);
    rom[3] = ins(OP_LED, 0, 3, 0);
    rom[4] = ins(OP_MUL, 1, 1, 1);
    rom[5] = ins(OP_LED, 0, 1, 0);
    expect_led("mul_led", 8'h30);
    expect_led("mul_alias_led", 8'hC9);
    release_reset();
    busy_n = 0; first_len = 0; runs = 0; bad = 0; prev_busy = 1'b0; edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.oBusy && !prev_busy) runs++;
      if (bus.oBusy) begin
        busy_n++;
        if (runs == 1) first_len++;
        if (bus.oIP !== ((runs == 1) ? 8'd3 : 8'd5)) bad++;
      end
      prev_busy = bus.oBusy;
    end while (!bus.oHalted && edges < 100);
    check("mul_halted",      {31'd0, bus.oHalted}, 32'd1);
    check("mul_busy_runs",   runs,      32'd2);
    check("mul_first_len",   first_len, 32'd16);
    check("mul_busy_total",  busy_n,    32'd32);
    check("mul_ip_hold_bad", bad,       32'd0);

    // Seed R9 for the taken-branch test
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(9, 16'h0042);
    rom[1] = ins(OP_LED, 0, 9, 0);
    expect_led("r9_seed_led", 8'h42);
    release_reset();
    run_to_halt("r9_seed", 50, edges);

    // Taken BLE (1 <= 2) back to 0: IP runs 0,1,2,3,0,... and STO R9 is flushed
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(1, 16'h0001);
    rom[1] = sto(2, 16'h0002);
    rom[2] = ins(OP_BLE, 0, 1, 2);
    rom[3] = sto(9, 16'hDEAD);
    release_reset();
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.oIP !== 8'(k % 4)) bad++;
    end
    check("ble_taken_ip_bad", bad, 32'd0);

    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = ins(OP_LED, 0, 9, 0);
    expect_led("r9_untouched_led", 8'h42);
    release_reset();
    run_to_halt("r9_read", 50, edges);

    // Untaken BLE (3 <= 2 false): no bubble, STO R9 executes, then HALT freezes IP at 6
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(1, 16'h0003);
    rom[1] = sto(2, 16'h0002);
    rom[2] = ins(OP_BLE, 0, 1, 2);
    rom[3] = sto(9, 16'hDEAD);
    rom[4] = ins(OP_LED, 0, 9, 0);
    expect_led("ble_untaken_led", 8'hAD);
    release_reset();
    run_to_halt("ble_untaken", 50, edges);
    check("ble_untaken_edges", edges, 32'd7);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.oIP !== 8'd6 || bus.oHalted !== 1'b1) bad++;
    end
    check("halt_freeze_bad", bad, 32'd0);

    // BEQ taken to 5, JMP to 7, LED R1; two one-cycle penalties
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(1, 16'h0007);
    rom[1] = sto(2, 16'h0007);
    rom[2] = ins(OP_BEQ, 5, 1, 2);
    rom[3] = sto(9, 16'hBEEF);
    rom[5] = ins(OP_JMP, 7, 0, 0);
    rom[6] = sto(9, 16'hBEEF);
    rom[7] = ins(OP_LED, 0, 1, 0);
    expect_led("beq_jmp_led", 8'h07);
    release_reset();
    run_to_halt("beq_jmp", 50, edges);
    check("beq_jmp_edges", edges, 32'd9);

    // Seed R5, then abort a MUL into R5 with reset 5 cycles in
    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(5, 16'h0055);
    rom[1] = ins(OP_LED, 0, 5, 0);
    expect_led("r5_seed_led", 8'h55);
    release_reset();
    run_to_halt("r5_seed", 50, edges);

    hold_reset();
    fill_rom({OP_HALT, 24'h0});
    rom[0] = sto(6, 16'h0002);
    rom[1] = ins(OP_MUL, 5, 6, 6);
    release_reset();
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!bus.oBusy && edges < 20);
    check("abort_mul_started", {31'd0, bus.oBusy}, 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, bus.oBusy}, 32'd1);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, bus.oBusy}, 32'd0);
    check("abort_ip",   {24'd0, bus.oIP},   32'd0);
    fill_rom({OP_HALT, 24'h0});
    rom[0] = ins(OP_LED, 0, 5, 0);
    expect_led("abort_r5_led", 8'h55);
    @(posedge clk);
    #1 rst = 1'b0;
    run_to_halt("abort_read", 50, edges);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/mini_alu_gen2.md
MINI_ALU_GEN2 -- requirements
Module: mini_alu_gen2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the data path and register-file word width (>=8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving the register-file address width, the instruction-address width and the operand field width; the register file has depth 2^ADDR_WIDTH.
REQ-003 The block SHALL have parameter LED_WIDTH, default 8, giving the LED output width (<=DATA_WIDTH).
REQ-004 Clock  input  1  system clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 iInstruction  input  4+3*ADDR_WIDTH  instruction word for the address on oIP (combinational ROM); fields are opcode[top 4], dest, src1, src0 (src0 in the LSBs).
REQ-007 oIP  output  ADDR_WIDTH  registered instruction pointer.
REQ-008 oLed  output  LED_WIDTH  registered LED value.
REQ-009 oBusy  output  1  high while a multiply is iterating.
REQ-010 oHalted  output  1  high after HALT has executed.

Function
REQ-011 The block SHALL be a two-stage fetch/execute machine: each non-stalled, non-halted edge captures iInstruction into the execute register and increments oIP by 1 (wrapping 2^ADDR_WIDTH-1 -> 0).
REQ-012 The execute stage SHALL read D0=RF[src0] and D1=RF[src1] combinationally; a register-file write SHALL occur at the end of the execute cycle, so the next instruction sees the written value.
REQ-013 IMM SHALL be {src1,src0}, zero-extended or truncated to DATA_WIDTH.
REQ-014 Opcodes: 0 NOP; 1 LED (oLed<=D1[LED_WIDTH-1:0]); 2 STO (RF[dest]<=IMM); 3 ADD (RF[dest]<=D1+D0); 4 SUB (RF[dest]<=D1-D0); 5 MUL; 6 SHL (RF[dest]<=D1<<D0[clog2(DATA_WIDTH)-1:0]); 7 SHR (logical, same amount rule); 8 BLE (taken if D1<=D0, unsigned); 9 BEQ (taken if D1==D0); A JMP (always taken); F HALT; B-E SHALL behave as NOP.
REQ-015 All arithmetic results SHALL be truncated to DATA_WIDTH bits (wrap-around, no flags).
REQ-016 Taken branch: oIP<=dest at the edge ending the branch cycle, and the instruction captured on that edge SHALL be replaced by NOP (one-cycle penalty, no delay slot).
REQ-017 An untaken branch SHALL cost no extra cycle.
REQ-018 MUL SHALL be an iterative shift-add taking exactly DATA_WIDTH execute cycles; oBusy is high for all of those cycles.
REQ-019 MUL SHALL write the low DATA_WIDTH bits of D1*D0 to RF[dest] at the end of the last cycle.
REQ-020 MUL operands SHALL be latched in the first cycle, so dest==src is legal.
REQ-021 While oBusy is high, oIP and the execute register SHALL hold, and no other write or LED update SHALL occur.
REQ-022 HALT: oHalted<=1 at the end of its execute cycle; thereafter oIP holds, the execute register holds NOP, and no register-file, LED or IP updates occur until Reset.
REQ-023 The register file SHALL be single-write, dual-read, and SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-024 While Reset is high at an edge: oIP=0, execute register=NOP, oLed=0, oBusy=0, oHalted=0, multiply counter cleared.
REQ-025 A Reset during a MUL or while halted SHALL abort it with no register-file write.
REQ-026 The first instruction executed after Reset falls SHALL be the one at address 0.
REQ-027 Reset SHALL take priority over every other event in the same cycle, including a branch, a MUL completion or HALT.

Verification (DATA_WIDTH=16, ADDR_WIDTH=8, LED_WIDTH=8)
REQ-028 Hold Reset for 2 cycles -> oIP=0, oLed=0x00, oBusy=0, oHalted=0; after release oIP counts 0,1,2...
REQ-029 Program STO R1,0x0005; STO R2,0x0003; ADD R3,R1,R2; LED src1=R3 -> oLed=0x08 one edge after LED executes.
REQ-030 STO R1,3; STO R2,5; SUB R3=R1-R2; LED R3 -> oLed=0xFE (RF[3]=0xFFFE, wrap-around).
REQ-031 STO R1,0x0123; STO R2,0x0010; MUL R3; LED R3 -> oBusy high for exactly 16 cycles, oIP constant throughout, then oLed=0x30 (RF[3]=0x1230).
REQ-032 Loop: BLE to address 0 with a STO R9,0xDEAD immediately after the branch; taken case -> RF[9] never written and oIP=0 on the next edge; untaken case -> RF[9]=0xDEAD with no bubble.
REQ-033 HALT -> oHalted=1 and oIP frozen for >=10 cycles; separately, assert Reset 5 cycles into a MUL -> RF[dest] unchanged, oBusy=0, oIP=0.
